ram_arbiter: RTL and testbench
==============================

// Module: ram_arbiter
// PURPOSE
//  Shares the single-port 8-bit program/data RAM between two requesters:
//  port A (CPU, primary) and port B (loader/debug DMA). One access per cycle.
//  Supports locked bursts and bounds how long the losing side can be starved.
//  Sits between the requesters and the RAM.
//  Drives the RAM's we/addr/di and returns its registered-address read data.
// PARAMETERS
//  ADDR_BITS  13  RAM address width (8 KB deep)
//  WIDTH      8   data width
//  MAX_WAIT   15  max cycles a requesting side may be denied before forced grant (>=1)
// PORTS
//  clk        in   1          system clock, all logic on posedge
//  rst        in   1          synchronous, active-high reset
//  a_req      in   1          A requests an access this cycle
//  a_lock     in   1          A wants to keep the RAM after this access (burst)
//  a_we       in   1          A access is a write
//  a_addr     in   ADDR_BITS  A address
//  a_di       in   WIDTH      A write data
//  a_gnt      out  1          A access accepted this cycle (combinational)
//  a_rvalid   out  1          a_do holds A's read data (cycle after granted read)
//  a_do       out  WIDTH      A read data
//  b_*        —    —          identical set for requester B
//  ram_we     out  1          to RAM we
//  ram_addr   out  ADDR_BITS  to RAM addr
//  ram_di     out  WIDTH      to RAM di
//  ram_do     in   WIDTH      from RAM do (reflects addr registered last cycle)
// BEHAVIOUR
//  - Reset (rst=1 at posedge): state=IDLE, wait_a=wait_b=0, last=B (A favoured),
//    a/b_rvalid=0. While rst=1: a/b_gnt=0, ram_we=0, ram_addr=0, ram_di=0.
//  - Grant is combinational from req, state, wait counters and last.
//    Exactly one of a_gnt/b_gnt is high when any req is high; neither otherwise.
//  - RAM mux: winner's we/addr/di drive ram_*.
//    No grant: ram_we=0, ram_addr holds the last granted address.
//  - Read latency 1: a granted read in cycle N gives x_rvalid=1 in N+1.
//    x_do=ram_do in that cycle. Write grant gives no rvalid.
//  - a_do/b_do always equal ram_do; only rvalid qualifies them.
//  - FSM states: IDLE, LOCK_A, LOCK_B.
//    IDLE -> LOCK_x when x is granted with x_lock=1.
//    LOCK_x -> IDLE when x_req=0, or x is granted with x_lock=0, or the other
//    side is starved.
//    While in LOCK_x with x_req=1, x is granted unless the other side is starved.
//  - Priority in IDLE: a starved side (wait==MAX_WAIT) wins; if both, A wins.
//    Otherwise fixed/round-robin per CONFIGURATION.
//  - wait_x: +1 per cycle with x_req=1 and x_gnt=0, saturating at MAX_WAIT.
//    Cleared on x_gnt or x_req=0.
//  - last: updates to the granted side every granted cycle.
//  - Requester contract: hold req/we/addr/di stable until gnt. Dropping req
//    before gnt is legal and cancels the request with no RAM side effect.
//  - Reset mid-burst: lock is discarded, and a read granted in the reset cycle
//    yields no rvalid.
// CONFIGURATION
//  RAM_ARB_RR_EN defined:
//    IDLE ties go to the side != last (alternating on continuous contention).
//  RAM_ARB_RR_EN undefined:
//    IDLE ties always go to A. B progresses only via starvation
//    (at most one B grant per MAX_WAIT+1 cycles under full A load).
//  Starvation guard and lock are present in both builds.
// TESTING
//  1 Single reads: A reads 0x0000 then B reads 0x1FFF, no contention ->
//    gnt same cycle; rvalid next cycle; do = ROM contents at those addresses.
//  2 Write/readback: B writes 0xA5 to 0x0100, then A reads 0x0100 ->
//    a_do=0xA5 with a_rvalid one cycle after a_gnt.
//  3 Contention, RR build: A and B both hold req for 8 cycles ->
//    grants alternate starting with A.
//    Non-RR build: A gets 8 grants, B gets 0 (MAX_WAIT=15).
//  4 Starvation: non-RR, A requests every cycle with a_lock=1,
//    B requests from cycle 0 -> b_gnt exactly at cycle 15;
//    A is regranted at 16 and LOCK_A is dropped.
//  5 Burst: A locked 4-word read of 0x0010..0x0013 with B requesting,
//    MAX_WAIT=15 -> 4 consecutive a_gnt, then b_gnt, rvalid each cycle.
//  6 Reset in LOCK_A mid-burst -> next cycle state IDLE, no gnt, rvalid=0,
//    ram_we=0. B alone then granted on first req after rst falls.

Source files
------------

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port RAM between requester A (CPU, primary)
// and requester B (loader/debug DMA). One access per cycle, combinational
// grant, locked bursts, and a bounded-starvation guard for the losing side.
// Optional feature macro: RAM_ARB_RR_EN -- when defined, IDLE ties alternate
// between the two sides; when undefined, IDLE ties always go to A.
module ram_arbiter #(
    parameter int ADDR_BITS = 13,
    parameter int WIDTH     = 8,
    parameter int MAX_WAIT  = 15
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 a_req,
    input  logic                 a_lock,
    input  logic                 a_we,
    input  logic [ADDR_BITS-1:0] a_addr,
    input  logic [WIDTH-1:0]     a_di,
    output logic                 a_gnt,
    output logic                 a_rvalid,
    output logic [WIDTH-1:0]     a_do,

    input  logic                 b_req,
    input  logic                 b_lock,
    input  logic                 b_we,
    input  logic [ADDR_BITS-1:0] b_addr,
    input  logic [WIDTH-1:0]     b_di,
    output logic                 b_gnt,
    output logic                 b_rvalid,
    output logic [WIDTH-1:0]     b_do,

    output logic                 ram_we,
    output logic [ADDR_BITS-1:0] ram_addr,
    output logic [WIDTH-1:0]     ram_di,
    input  logic [WIDTH-1:0]     ram_do
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_A = 2'd1,
        LOCK_B = 2'd2
    } state_t;

    state_t                 state;
    logic [WAIT_W-1:0]      wait_a;
    logic [WAIT_W-1:0]      wait_b;
    logic [ADDR_BITS-1:0]   addr_hold_p1;
    logic                   rd_vld_a_p1;
    logic                   rd_vld_b_p1;
    logic                   starved_a;
    logic                   starved_b;
    logic                   tie_to_a;

    // Denial counter step: counts up and sticks at the starvation threshold.
    function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v);
        if (v >= WAIT_MAX)
            return WAIT_MAX;
        else
            return v + 1'b1;
    endfunction

    // A side only counts as starved while it is still asking for the RAM.
    assign starved_a = a_req && (wait_a == WAIT_MAX);
    assign starved_b = b_req && (wait_b == WAIT_MAX);

`ifdef RAM_ARB_RR_EN
    // Side that won the most recent granted cycle; only steers IDLE ties.
    logic last_b;

    // Track the most recent winner so contention alternates.
    always_ff @(posedge clk) begin
        if (rst)
            last_b <= 1'b1;
        else if (a_gnt)
            last_b <= 1'b0;
        else if (b_gnt)
            last_b <= 1'b1;
    end

    assign tie_to_a = last_b;
`else
    assign tie_to_a = 1'b1;
`endif

    // Grant decision: lock owner keeps the RAM unless the other side is starved.
    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (!rst) begin
            if (state == LOCK_A && a_req && !starved_b) begin
                a_gnt = 1'b1;
            end else if (state == LOCK_B && b_req && !starved_a) begin
                b_gnt = 1'b1;
            end else if (a_req && b_req) begin
                if (starved_a)
                    a_gnt = 1'b1;
                else if (starved_b)
                    b_gnt = 1'b1;
                else if (tie_to_a)
                    a_gnt = 1'b1;
                else
                    b_gnt = 1'b1;
            end else begin
                a_gnt = a_req;
                b_gnt = b_req;
            end
        end
    end

    // RAM mux: winner drives the RAM; with no winner the address parks.
    always_comb begin
        ram_we   = 1'b0;
        ram_addr = addr_hold_p1;
        ram_di   = '0;
        if (a_gnt) begin
            ram_we   = a_we;
            ram_addr = a_addr;
            ram_di   = a_di;
        end else if (b_gnt) begin
            ram_we   = b_we;
            ram_addr = b_addr;
            ram_di   = b_di;
        end else if (rst) begin
            ram_addr = '0;
        end
    end

    // Control state: lock FSM, starvation counters, parked address, read valids.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            wait_a       <= '0;
            wait_b       <= '0;
            addr_hold_p1 <= '0;
            rd_vld_a_p1  <= 1'b0;
            rd_vld_b_p1  <= 1'b0;
        end else begin
            rd_vld_a_p1 <= a_gnt && !a_we;
            rd_vld_b_p1 <= b_gnt && !b_we;
            wait_a      <= (a_req && !a_gnt) ? sat_inc(wait_a) : '0;
            wait_b      <= (b_req && !b_gnt) ? sat_inc(wait_b) : '0;
            if (a_gnt || b_gnt)
                addr_hold_p1 <= ram_addr;
            case (state)
                IDLE: begin
                    if (a_gnt && a_lock)
                        state <= LOCK_A;
                    else if (b_gnt && b_lock)
                        state <= LOCK_B;
                end
                LOCK_A: begin
                    if (!a_req || (a_gnt && !a_lock) || starved_b)
                        state <= IDLE;
                end
                LOCK_B: begin
                    if (!b_req || (b_gnt && !b_lock) || starved_a)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // RAM read data is shared; rvalid tells each side when it is theirs.
    assign a_do     = ram_do;
    assign b_do     = ram_do;
    assign a_rvalid = rd_vld_a_p1;
    assign b_rvalid = rd_vld_b_p1;

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter: directed scenarios plus randomized traffic,
// checked against a rule-level arbitration model and a shadow memory.
module tb_ram_arbiter;

    localparam int AW = 13;
    localparam int DW = 8;
    localparam int MW = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_req, a_lock, a_we, b_req, b_lock, b_we;
    logic [AW-1:0] a_addr, b_addr, ram_addr;
    logic [DW-1:0] a_di, b_di, a_do, b_do, ram_di, ram_do;
    logic          a_gnt, a_rvalid, b_gnt, b_rvalid, ram_we;

    always #5 clk = ~clk;

    ram_arbiter #(.ADDR_BITS(AW), .WIDTH(DW), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_lock(a_lock), .a_we(a_we), .a_addr(a_addr), .a_di(a_di),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_do(a_do),
        .b_req(b_req), .b_lock(b_lock), .b_we(b_we), .b_addr(b_addr), .b_di(b_di),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_do(b_do),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_di(ram_di), .ram_do(ram_do)
    );

    function automatic logic [DW-1:0] rom(input int i);
        return DW'(i * 7 + (i >> 5)) ^ 8'h3C;
    endfunction

    // Bench RAM: registered address, write on we.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [AW-1:0] ram_addr_q;
    bit            mem_init_done = 1'b0;
    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= rom(i);
            mem_init_done <= 1'b1;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_di;
        end
        ram_addr_q <= ram_addr;
    end
    assign ram_do = mem[ram_addr_q];

    // Scoreboard and counters
    typedef struct { int cyc; logic [DW-1:0] d; } exp_t;
    exp_t qa[$];
    exp_t qb[$];
    int ncmp = 0;
    int nfail = 0;
    int cyc = 0;

    // Model state: lock owner 0 none / 1 A / 2 B
    int            owner, wa, wb;
    bit            last_b;
    logic [AW-1:0] m_hold;
    logic [DW-1:0] shadow [0:(1<<AW)-1];
    bit            ga_m, gb_m;
    bit            dut_ag, dut_bg;

    task automatic chk(input bit ok, input string name, input longint act, input longint req);
        ncmp++;
        if (!ok) begin
            nfail++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: read data must appear exactly one cycle after a read grant.
    always @(negedge clk) begin
        while (qa.size() > 0 && qa[0].cyc < cyc - 1) begin
            chk(1'b0, "a_rvalid_missing", 0, 1);
            void'(qa.pop_front());
        end
        while (qb.size() > 0 && qb[0].cyc < cyc - 1) begin
            chk(1'b0, "b_rvalid_missing", 0, 1);
            void'(qb.pop_front());
        end
        if (a_rvalid === 1'b1) begin
            if (qa.size() > 0 && qa[0].cyc == cyc - 1) begin
                chk(a_do == qa[0].d, "a_do", a_do, qa[0].d);
                void'(qa.pop_front());
            end else begin
                chk(1'b0, "a_rvalid_unexpected", 1, 0);
            end
        end
        if (b_rvalid === 1'b1) begin
            if (qb.size() > 0 && qb[0].cyc == cyc - 1) begin
                chk(b_do == qb[0].d, "b_do", b_do, qb[0].d);
                void'(qb.pop_front());
            end else begin
                chk(1'b0, "b_rvalid_unexpected", 1, 0);
            end
        end
    end

    task automatic model_reset();
        owner = 0; wa = 0; wb = 0; last_b = 1'b1; m_hold = '0;
    endtask

    // One clock: check at negedge, advance model, then move past posedge.
    task automatic step();
        bit sa, sb;
        exp_t e;
        @(negedge clk);
        dut_ag = a_gnt;
        dut_bg = b_gnt;
        ga_m = 1'b0;
        gb_m = 1'b0;
        if (rst) begin
            chk({a_gnt, b_gnt, ram_we} == 3'b000 && ram_addr == '0 && ram_di == '0,
                "reset_outputs", {a_gnt, b_gnt, ram_we, 3'b0, ram_addr}, 0);
            model_reset();
        end else begin
            sa = a_req && wa == MW;
            sb = b_req && wb == MW;
            if (a_req && b_req) begin
                if (owner == 1 && !sb)      ga_m = 1'b1;
                else if (owner == 2 && !sa) gb_m = 1'b1;
                else if (sa)                ga_m = 1'b1;
                else if (sb)                gb_m = 1'b1;
                else begin
`ifdef RAM_ARB_RR_EN
                    ga_m = last_b;
`else
                    ga_m = 1'b1;
`endif
                    gb_m = !ga_m;
                end
            end else begin
                ga_m = a_req;
                gb_m = b_req;
            end
            chk({a_gnt, b_gnt} == {ga_m, gb_m}, "grant", {a_gnt, b_gnt}, {ga_m, gb_m});
            if (ga_m) begin
                chk(ram_we == a_we && ram_addr == a_addr && (a_we ? ram_di == a_di : 1'b1),
                    "ram_mux_a", {ram_we, ram_addr}, {a_we, a_addr});
                if (!a_we) begin e.cyc = cyc; e.d = shadow[a_addr]; qa.push_back(e); end
                else shadow[a_addr] = a_di;
                m_hold = a_addr;
                last_b = 1'b0;
            end else if (gb_m) begin
                chk(ram_we == b_we && ram_addr == b_addr && (b_we ? ram_di == b_di : 1'b1),
                    "ram_mux_b", {ram_we, ram_addr}, {b_we, b_addr});
                if (!b_we) begin e.cyc = cyc; e.d = shadow[b_addr]; qb.push_back(e); end
                else shadow[b_addr] = b_di;
                m_hold = b_addr;
                last_b = 1'b1;
            end else begin
                chk(ram_we == 1'b0 && ram_addr == m_hold, "ram_park",
                    {ram_we, ram_addr}, {1'b0, m_hold});
            end
            if (owner == 0)
                owner = (ga_m && a_lock) ? 1 : (gb_m && b_lock) ? 2 : 0;
            else if (owner == 1) begin
                if (!a_req || (ga_m && !a_lock) || sb) owner = 0;
            end else begin
                if (!b_req || (gb_m && !b_lock) || sa) owner = 0;
            end
            wa = (a_req && !ga_m) ? ((wa < MW) ? wa + 1 : MW) : 0;
            wb = (b_req && !gb_m) ? ((wb < MW) ? wb + 1 : MW) : 0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clr();
        a_req = 0; a_lock = 0; a_we = 0; a_addr = '0; a_di = '0;
        b_req = 0; b_lock = 0; b_we = 0; b_addr = '0; b_di = '0;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) step();
        rst = 1'b0;
    endtask

    task automatic gen(output logic req, output logic lock, output logic we,
                       output logic [AW-1:0] addr, output logic [DW-1:0] di);
        req  = 1'b1;
        we   = ($urandom_range(0, 2) == 0);
        lock = ($urandom_range(0, 3) == 0);
        addr = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom);
        di   = DW'($urandom);
    endtask

    initial begin
        int cnt, first_b;
        for (int i = 0; i < (1 << AW); i++) shadow[i] = rom(i);
        model_reset();
        clr();
        do_reset(3);
        step();

        // Single reads, no contention
        a_req = 1; a_addr = 13'h0000; step(); clr(); step();
        b_req = 1; b_addr = 13'h1FFF; step(); clr(); step();

        // Write then read back
        b_req = 1; b_we = 1; b_addr = 13'h0100; b_di = 8'hA5; step(); clr();
        a_req = 1; a_addr = 13'h0100; step(); clr();
        chk(a_rvalid == 1'b1 && a_do == 8'hA5, "readback_A5", {a_rvalid, a_do}, 9'h1A5);
        step();

        // Continuous contention for 8 cycles
        do_reset(1);
        a_req = 1; a_addr = 13'h0020; b_req = 1; b_addr = 13'h0040;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin step(); if (dut_ag) cnt++; end
`ifdef RAM_ARB_RR_EN
        chk(cnt == 4, "contention_a_count", cnt, 4);
`else
        chk(cnt == 8, "contention_a_count", cnt, 8);
`endif
        clr(); step(); step();

        // Starvation against a locked A
        do_reset(1);
        a_req = 1; a_lock = 1; a_addr = 13'h0005; b_req = 1; b_addr = 13'h0006;
        first_b = -1;
        for (int i = 0; i < 17; i++) begin
            step();
            if (dut_bg && first_b < 0) first_b = i;
            if (gb_m) b_req = 0;
        end
        chk(first_b == 15, "starve_b_cycle", first_b, 15);
        clr(); step(); step();

        // Locked 4-word burst with B waiting
        do_reset(1);
        a_req = 1; a_lock = 1; a_addr = 13'h0010; b_req = 1; b_addr = 13'h0200;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (ga_m) begin
                cnt++;
                a_addr = a_addr + 1'b1;
                a_lock = (cnt < 3);
                if (cnt == 4) a_req = 0;
            end
            if (gb_m) b_req = 0;
        end
        chk(cnt == 4, "burst_len", cnt, 4);
        clr(); step(); step();

        // Reset mid-burst, then B alone
        a_req = 1; a_lock = 1; a_addr = 13'h0030;
        step(); a_addr = 13'h0031; step();
        rst = 1'b1; step(); rst = 1'b0;
        clr();
        chk(a_rvalid == 1'b0 && ram_we == 1'b0, "post_reset_quiet", {a_rvalid, ram_we}, 0);
        b_req = 1; b_addr = 13'h0033; step();
        chk(dut_bg == 1'b1, "b_after_reset", dut_bg, 1);
        clr(); step(); step();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 399) == 0);
            step();
            if (!a_req || ga_m) begin
                if ($urandom_range(0, 3) != 0) gen(a_req, a_lock, a_we, a_addr, a_di);
                else a_req = 0;
            end else if ($urandom_range(0, 19) == 0) a_req = 0;
            if (!b_req || gb_m) begin
                if ($urandom_range(0, 2) != 0) gen(b_req, b_lock, b_we, b_addr, b_di);
                else b_req = 0;
            end else if ($urandom_range(0, 19) == 0) b_req = 0;
        end
        rst = 1'b0;
        clr();
        repeat (3) step();
        chk(qa.size() == 0 && qb.size() == 0, "scoreboard_drained", qa.size() + qb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
